// File: rtl/booth_pp_accumulator.sv
// rtl/booth_pp_accumulator.sv - sequential reducer of radix-4 Booth partial products
// Folds one shifted partial product per cycle into a 16-bit accumulator.
module booth_pp_accumulator #(
  parameter int PP_W       = 10,
  parameter int NUM_PP     = 4,
  parameter int OUT_W      = 16,
  parameter int SHIFT_STEP = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PP_W-1:0]  pp1,
  input  logic [PP_W-1:0]  pp2,
  input  logic [PP_W-1:0]  pp3,
  input  logic [PP_W-1:0]  pp4,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] product,
  output logic             busy
);

  localparam int CNT_W = $clog2(NUM_PP);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [OUT_W-1:0] acc;
  logic [OUT_W-1:0] acc_sum;
  logic [OUT_W-1:0] term;
  logic [OUT_W-1:0] product_q;
  logic [PP_W-1:0]  pp2_q;
  logic [PP_W-1:0]  pp3_q;
  logic [PP_W-1:0]  pp4_q;
  logic [PP_W-1:0]  pp_sel;
  logic             accept;
  logic             last_step;
  int               sh_amt;

  function automatic logic [OUT_W-1:0] sext(input logic [PP_W-1:0] p);
    return {{(OUT_W-PP_W){p[PP_W-1]}}, p};
  endfunction

  assign accept    = (state == IDLE) && in_valid;
  assign last_step = (cnt == CNT_W'(NUM_PP-1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = ACC;
      end
      ACC: begin
        busy = 1'b1;
        if (last_step) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Captured copies decouple the result from whatever the producer drives after accept.
  always_comb begin
    case (cnt)
      CNT_W'(1): pp_sel = pp2_q;
      CNT_W'(2): pp_sel = pp3_q;
      default:   pp_sel = pp4_q;
    endcase
  end

  assign sh_amt  = int'(cnt) * SHIFT_STEP;
  assign term    = sext(pp_sel) << sh_amt;
  assign acc_sum = acc + term;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc       <= '0;
      cnt       <= '0;
      pp2_q     <= '0;
      pp3_q     <= '0;
      pp4_q     <= '0;
      product_q <= '0;
    end else if (accept) begin
      pp2_q <= pp2;
      pp3_q <= pp3;
      pp4_q <= pp4;
      acc   <= sext(pp1);
      cnt   <= CNT_W'(1);
    end else if (state == ACC) begin
      acc <= acc_sum;
      cnt <= cnt + CNT_W'(1);
      // The product register only moves on completion, so no partial sum is ever visible.
      if (last_step) product_q <= acc_sum;
    end
  end

  assign product = product_q;

endmodule
